branch_resolve_unit: RTL and testbench

//  Parametrised successor to the combinational branch-condition mux. Compares its own operands,

---
 rtl/branch_pkg.sv | 49 ++++
 rtl/branch_pred_table.sv | 37 +++
 rtl/branch_resolve_unit.sv | 153 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants, FSM state and branch-decision helpers for branch_resolve_unit.
package branch_pkg;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned IMM_W = 16;

    localparam logic [OPC_W-1:0] OP_BLT = 6'd1;
    localparam logic [OPC_W-1:0] OP_BEQ = 6'd4;
    localparam logic [OPC_W-1:0] OP_BNE = 6'd5;
    localparam logic [OPC_W-1:0] OP_BLE = 6'd6;
    localparam logic [OPC_W-1:0] OP_BGT = 6'd7;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_MAX   = 2'b11;
    localparam logic [1:0] CTR_MIN   = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESOLVE
    } state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_flags_t;

    // True when the opcode belongs to the resolved branch set.
    function automatic logic op_is_branch(input logic [OPC_W-1:0] op);
        case (op)
            OP_BLT, OP_BEQ, OP_BNE, OP_BLE, OP_BGT: op_is_branch = 1'b1;
            default:                                op_is_branch = 1'b0;
        endcase
    endfunction

    // Taken condition for each branch opcode; non-branches never take.
    function automatic logic op_taken(input logic [OPC_W-1:0] op, input cmp_flags_t f);
        case (op)
            OP_BEQ:  op_taken = f.eq;
            OP_BNE:  op_taken = !f.eq;
            OP_BLE:  op_taken = !f.gt;
            OP_BGT:  op_taken = f.gt;
            OP_BLT:  op_taken = f.lt;
            default: op_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_pred_table.sv
// Table of 2-bit saturating branch predictors with one read and one update port.
module branch_pred_table
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_bit,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr [DEPTH];

    // Prediction is the counter MSB.
    assign rd_bit = ctr[rd_idx][1];

    // Saturating increment on taken, decrement on not taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ctr[i] <= CTR_RESET;
            end
        end else if (upd_en) begin
            if (upd_taken && (ctr[upd_idx] != CTR_MAX)) begin
                ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
            end else if (!upd_taken && (ctr[upd_idx] != CTR_MIN)) begin
                ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compares operands, resolves the decision, computes the target
// and trains a 2-bit predictor. Fixed latency: accept in N, res_valid in N+2.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned PRED_DEPTH = 16,
    parameter bit          SIGNED_CMP = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [IMM_W-1:0]    imm,
    input  logic                flush,
    output logic                res_valid,
    output logic                res_is_branch,
    output logic                res_taken,
    output logic                res_pred,
    output logic                res_mispred,
`ifdef BRANCH_STATS_EN
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispreds,
`endif
    output logic [PC_WIDTH-1:0] res_target
);

    localparam int unsigned IDX_W = $clog2(PRED_DEPTH);

    state_t                state_q, state_d;
    logic                  accept;
    logic                  resolve_en;
    logic [OPC_W-1:0]      opcode_q;
    logic [WIDTH-1:0]      a_q, b_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [IMM_W-1:0]      imm_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  pred_q;
    logic                  rd_bit;
    cmp_flags_t            flags_c;
    logic                  br_c, taken_c;
    logic [PC_WIDTH-1:0]   imm_ext_c, target_c;

    assign req_ready  = (state_q == IDLE);
    assign accept     = req_valid && req_ready;
    assign resolve_en = (state_q == RESOLVE) && !flush;
    assign res_valid  = resolve_en;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush aborts only once the request is in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = CMP;
            CMP:     state_d = flush ? IDLE : RESOLVE;
            RESOLVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and prediction read at accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
            idx_q    <= '0;
            pred_q   <= 1'b0;
        end else if (accept) begin
            opcode_q <= opcode;
            a_q      <= op_a;
            b_q      <= op_b;
            pc_q     <= pc;
            imm_q    <= imm;
            idx_q    <= pc[IDX_W+1:2];
            pred_q   <= rd_bit;
        end
    end

    // Operand compare, decision and target for the latched request.
    always_comb begin
        flags_c    = '0;
        flags_c.eq = (a_q == b_q);
        if (SIGNED_CMP) begin
            flags_c.gt = ($signed(a_q) > $signed(b_q));
            flags_c.lt = ($signed(a_q) < $signed(b_q));
        end else begin
            flags_c.gt = (a_q > b_q);
            flags_c.lt = (a_q < b_q);
        end
        br_c      = op_is_branch(opcode_q);
        taken_c   = br_c && op_taken(opcode_q, flags_c);
        imm_ext_c = PC_WIDTH'($signed(imm_q));
        target_c  = pc_q + PC_WIDTH'(4) + (imm_ext_c << 2);
    end

    // Result registers load at the end of CMP and hold until the next result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_is_branch <= 1'b0;
            res_taken     <= 1'b0;
            res_pred      <= 1'b0;
            res_mispred   <= 1'b0;
            res_target    <= '0;
        end else if ((state_q == CMP) && !flush) begin
            res_is_branch <= br_c;
            res_taken     <= taken_c;
            res_pred      <= pred_q;
            res_mispred   <= br_c && (pred_q != taken_c);
            res_target    <= target_c;
        end
    end

    branch_pred_table #(
        .DEPTH (PRED_DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (pc[IDX_W+1:2]),
        .rd_bit    (rd_bit),
        .upd_en    (resolve_en && res_is_branch),
        .upd_idx   (idx_q),
        .upd_taken (res_taken)
    );

`ifdef BRANCH_STATS_EN
    // Branch and mispredict counters, advanced only by completed requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches <= '0;
            stat_mispreds <= '0;
        end else if (resolve_en) begin
            if (res_is_branch) stat_branches <= stat_branches + 32'd1;
            if (res_mispred)   stat_mispreds <= stat_mispreds + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit (signed and unsigned instances).
module tb_branch_resolve_unit;
    import branch_pkg::*;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [15:0] imm;
        logic        br;
        logic        tk;
        logic        tku;
        logic        pr;
        logic [31:0] tgt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [5:0]  opcode;
    logic [31:0] op_a, op_b, pc;
    logic [15:0] imm;
    logic        flush;

    logic        req_ready, res_valid, res_is_branch, res_taken, res_pred, res_mispred;
    logic [31:0] res_target;
    logic        ru_ready, ru_valid, ru_is_branch, ru_taken, ru_pred, ru_mispred;
    logic [31:0] ru_target;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_mispreds, su_branches, su_mispreds;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int snap;
    vec_t vecs [12];
    vec_t v;

    always #5 clk = ~clk;

    branch_resolve_unit #(.SIGNED_CMP(1'b1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .op_a(op_a), .op_b(op_b), .pc(pc), .imm(imm), .flush(flush),
        .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
        .res_pred(res_pred), .res_mispred(res_mispred),
`ifdef BRANCH_STATS_EN
        .stat_branches(stat_branches), .stat_mispreds(stat_mispreds),
`endif
        .res_target(res_target)
    );

    branch_resolve_unit #(.SIGNED_CMP(1'b0)) u_dut_u (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ru_ready),
        .opcode(opcode), .op_a(op_a), .op_b(op_b), .pc(pc), .imm(imm), .flush(flush),
        .res_valid(ru_valid), .res_is_branch(ru_is_branch), .res_taken(ru_taken),
        .res_pred(ru_pred), .res_mispred(ru_mispred),
`ifdef BRANCH_STATS_EN
        .stat_branches(su_branches), .stat_mispreds(su_mispreds),
`endif
        .res_target(ru_target)
    );

    always @(negedge clk) if (res_valid === 1'b1) pulses++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(string n, logic [5:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] p, logic [15:0] im, logic br, logic tk,
                                logic tku, logic pr, logic [31:0] tgt);
        vec_t r;
        r.name = n; r.op = op; r.a = a; r.b = b; r.pc = p; r.imm = im;
        r.br = br; r.tk = tk; r.tku = tku; r.pr = pr; r.tgt = tgt;
        return r;
    endfunction

    // Present one request and hold it for exactly the accept edge.
    task automatic send(input vec_t t);
        @(negedge clk);
        chk({t.name, "_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; opcode = t.op; op_a = t.a; op_b = t.b; pc = t.pc; imm = t.imm;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Full transaction: latency and every result field against the vector.
    task automatic run_vec(input vec_t t);
        send(t);
        @(negedge clk);
        chk({t.name, "_valid_n1"}, 64'(res_valid), 64'd0);
        chk({t.name, "_busy"}, 64'(req_ready), 64'd0);
        @(negedge clk);
        chk({t.name, "_valid_n2"}, 64'(res_valid), 64'd1);
        chk({t.name, "_isbr"}, 64'(res_is_branch), 64'(t.br));
        chk({t.name, "_taken"}, 64'(res_taken), 64'(t.tk));
        chk({t.name, "_pred"}, 64'(res_pred), 64'(t.pr));
        chk({t.name, "_mispred"}, 64'(res_mispred), 64'(t.br && (t.pr != t.tk)));
        chk({t.name, "_target"}, 64'(res_target), 64'(t.tgt));
        chk({t.name, "_u_valid"}, 64'(ru_valid), 64'd1);
        chk({t.name, "_u_taken"}, 64'(ru_taken), 64'(t.tku));
        @(negedge clk);
        chk({t.name, "_valid_n3"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; flush = 1'b0;
        opcode = '0; op_a = '0; op_b = '0; pc = '0; imm = '0;

        //               name      op      a             b      pc            imm      br tk tku pr target
        vecs[0]  = mk("beq_eq",   OP_BEQ, 32'd5,        32'd5, 32'h100,      16'd3,    1, 1, 1, 0, 32'h110);
        vecs[1]  = mk("bgt_neg",  OP_BGT, 32'hFFFFFFFF, 32'd1, 32'h104,      16'd0,    1, 0, 1, 0, 32'h108);
        vecs[2]  = mk("bne",      OP_BNE, 32'd3,        32'd4, 32'h208,      16'hFFFF, 1, 1, 1, 0, 32'h208);
        vecs[3]  = mk("blt_neg",  OP_BLT, 32'hFFFFFFFB, 32'd2, 32'h30C,      16'hFFFE, 1, 1, 0, 0, 32'h308);
        vecs[4]  = mk("ble_eq",   OP_BLE, 32'd7,        32'd7, 32'h10,       16'd1,    1, 1, 1, 0, 32'h18);
        vecs[5]  = mk("ble_gt",   OP_BLE, 32'd8,        32'd7, 32'h14,       16'd0,    1, 0, 0, 0, 32'h18);
        vecs[6]  = mk("rtype",    6'd0,   32'd1,        32'd1, 32'h18,       16'd2,    0, 0, 0, 0, 32'h24);
        vecs[7]  = mk("wrap_hi",  OP_BEQ, 32'd0,        32'd1, 32'hFFFFFFFC, 16'd0,    1, 0, 0, 0, 32'h0);
        vecs[8]  = mk("neg_imm",  OP_BNE, 32'd1,        32'd1, 32'h0,        16'h8000, 1, 0, 0, 1, 32'hFFFE0004);
        vecs[9]  = mk("sat1",     OP_BEQ, 32'd2,        32'd2, 32'h40,       16'd0,    1, 1, 1, 0, 32'h44);
        vecs[10] = mk("sat2",     OP_BEQ, 32'd2,        32'd2, 32'h40,       16'd0,    1, 1, 1, 1, 32'h44);
        vecs[11] = mk("sat3",     OP_BEQ, 32'd2,        32'd2, 32'h40,       16'd0,    1, 1, 1, 1, 32'h44);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_res", 64'({res_is_branch, res_taken, res_pred, res_mispred}), 64'd0);
        chk("rst_target", 64'(res_target), 64'd0);
        for (int i = 0; i < 16; i++) chk($sformatf("rst_ctr%0d", i), 64'(u_dut.u_table.ctr[i]), 64'd1);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);
        chk("ctr_sat", 64'(u_dut.u_table.ctr[0]), 64'd3);
        chk("ctr_rtype", 64'(u_dut.u_table.ctr[6]), 64'd1);

        // Flush while in CMP: no pulse, ready next cycle, results held, table untouched.
        snap = pulses;
        v = mk("fl_cmp", OP_BEQ, 32'd1, 32'd1, 32'h20, 16'd0, 1, 1, 1, 0, 32'h24);
        send(v);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("fl_cmp_ready", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("fl_cmp_pulses", 64'(pulses), 64'(snap));
        chk("fl_cmp_hold_target", 64'(res_target), 64'h44);
        chk("fl_cmp_hold_taken", 64'(res_taken), 64'd1);
        chk("fl_cmp_ctr", 64'(u_dut.u_table.ctr[8]), 64'd1);

        // Flush while in RESOLVE: pulse suppressed, table untouched.
        send(v);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("fl_res_valid", 64'(res_valid), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("fl_res_ready", 64'(req_ready), 64'd1);
        chk("fl_res_pulses", 64'(pulses), 64'(snap));
        chk("fl_res_ctr", 64'(u_dut.u_table.ctr[8]), 64'd1);

        // Async reset in RESOLVE: pulse lost, table back to weak not-taken.
        v = mk("pre_rst", OP_BEQ, 32'd9, 32'd9, 32'h24, 16'd0, 1, 1, 1, 0, 32'h28);
        run_vec(v);
        chk("pre_rst_ctr", 64'(u_dut.u_table.ctr[9]), 64'd2);
        snap = pulses;
        send(v);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 64'(res_valid), 64'd0);
        chk("rst_mid_ready", 64'(req_ready), 64'd1);
        chk("rst_mid_taken", 64'(res_taken), 64'd0);
        chk("rst_mid_ctr", 64'(u_dut.u_table.ctr[9]), 64'd1);
        chk("rst_mid_pulses", 64'(pulses), 64'(snap));
        reset = 1'b0;

        // Two branches after reset: first mispredicts, second predicted taken.
        run_vec(mk("st1", OP_BEQ, 32'd3, 32'd3, 32'h28, 16'd0, 1, 1, 1, 0, 32'h2C));
        run_vec(mk("st2", OP_BEQ, 32'd3, 32'd3, 32'h28, 16'd0, 1, 1, 1, 1, 32'h2C));
`ifdef BRANCH_STATS_EN
        chk("stat_branches", 64'(stat_branches), 64'd2);
        chk("stat_mispreds", 64'(stat_mispreds), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
